// File: rtl/delay_timer_multi_if.sv
// Control/status bundle between the sequencing FSMs (master) and the
// multi-channel delay timer (slave).
interface delay_timer_multi_if #(
  parameter int CHANNELS = 2,
  parameter int COUNT_W  = 8
);
  logic                        enable;
  logic [CHANNELS-1:0]         start;
  logic [CHANNELS-1:0]         pause;
  logic [CHANNELS-1:0]         mode;
  logic [CHANNELS*COUNT_W-1:0] delay;
  logic [CHANNELS-1:0]         busy;
  logic [CHANNELS-1:0]         done;
  logic [CHANNELS-1:0]         done_pulse;
  logic [CHANNELS*COUNT_W-1:0] remaining;
  logic                        any_done;

  modport master (
    output enable, start, pause, mode, delay,
    input  busy, done, done_pulse, remaining, any_done
  );

  modport slave (
    input  enable, start, pause, mode, delay,
    output busy, done, done_pulse, remaining, any_done
  );
endinterface

// File: rtl/delay_timer_multi.sv
// Independent per-channel delay timers counting BASIC_PERIOD ticks per unit,
// one-shot (held done) or periodic (auto reload), sharing a global enable.
//
// state  | meaning
// IDLE   | no activity, count and sub at 0
// RUN    | counting down, busy high
// DONE   | one-shot expired, done held until next start or enable low
module delay_timer_multi #(
  parameter int CHANNELS     = 2,
  parameter int COUNT_W      = 8,
  parameter int PERIOD_W     = 20,
  parameter int BASIC_PERIOD = 500000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  delay_timer_multi_if.slave     tif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PERIOD_W-1:0] SUB_LAST = PERIOD_W'(BASIC_PERIOD - 1);

  logic [1:0]          r_state  [CHANNELS];
  logic [COUNT_W-1:0]  r_count  [CHANNELS];
  logic [COUNT_W-1:0]  r_reload [CHANNELS];
  logic [PERIOD_W-1:0] r_sub    [CHANNELS];
  logic [CHANNELS-1:0] r_mode;
  logic [CHANNELS-1:0] r_busy;
  logic [CHANNELS-1:0] r_done;
  logic [CHANNELS-1:0] r_pulse;

  logic [COUNT_W-1:0]          w_delay [CHANNELS];
  logic [CHANNELS*COUNT_W-1:0] w_remaining;

  always_comb begin
    w_remaining = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_delay[i] = tif.delay[i*COUNT_W +: COUNT_W];
      w_remaining[i*COUNT_W +: COUNT_W] = r_count[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i]  <= S_IDLE;
        r_count[i]  <= '0;
        r_reload[i] <= '0;
        r_sub[i]    <= '0;
      end
      r_mode  <= '0;
      r_busy  <= '0;
      r_done  <= '0;
      r_pulse <= '0;
    end else if (!tif.enable) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i]  <= S_IDLE;
        r_count[i]  <= '0;
        r_reload[i] <= '0;
        r_sub[i]    <= '0;
      end
      r_mode  <= '0;
      r_busy  <= '0;
      r_done  <= '0;
      r_pulse <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pulse[i] <= 1'b0;
        if (tif.start[i]) begin
          // start outranks pause and a coincident expiry
          r_count[i]  <= w_delay[i];
          r_reload[i] <= w_delay[i];
          r_mode[i]   <= tif.mode[i];
          r_sub[i]    <= '0;
          if (w_delay[i] != '0) begin
            r_state[i] <= S_RUN;
            r_busy[i]  <= 1'b1;
            r_done[i]  <= 1'b0;
          end else begin
            r_state[i] <= S_DONE;
            r_busy[i]  <= 1'b0;
            r_done[i]  <= 1'b1;
            r_pulse[i] <= 1'b1;
          end
        end else if (r_state[i] == S_RUN && !tif.pause[i]) begin
          if (r_sub[i] != SUB_LAST) begin
            r_sub[i] <= r_sub[i] + PERIOD_W'(1);
          end else begin
            r_sub[i] <= '0;
            if (r_count[i] == COUNT_W'(1)) begin
              r_pulse[i] <= 1'b1;
              if (r_mode[i]) begin
                r_count[i] <= r_reload[i];
              end else begin
                r_count[i] <= '0;
                r_state[i] <= S_DONE;
                r_busy[i]  <= 1'b0;
                r_done[i]  <= 1'b1;
              end
            end else begin
              r_count[i] <= r_count[i] - COUNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign tif.busy       = r_busy;
  assign tif.done       = r_done;
  assign tif.done_pulse = r_pulse;
  assign tif.remaining  = w_remaining;
  assign tif.any_done   = |r_done;

endmodule

// File: tb/tb_delay_timer_multi.sv
// Scoreboard bench for delay_timer_multi: a deadline-based reference model
// predicts levels and expiry edges; a monitor compares after every clock edge.
module tb_delay_timer_multi;
  localparam int CH = 2;
  localparam int CW = 8;
  localparam int PW = 20;
  localparam int BP = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // reference model: 0 idle, 1 run, 2 done; run expires when edge == deadline
  int            m_st [CH];
  int            m_dl [CH];
  int            m_d  [CH];
  bit            m_md [CH];
  logic [CH-1:0] m_busy;
  logic [CH-1:0] m_done;
  int            m_rem [CH];
  int            q_exp [CH][$];
  int            plog  [CH][$];

  delay_timer_multi_if #(.CHANNELS(CH), .COUNT_W(CW)) tif ();

  delay_timer_multi #(
    .CHANNELS(CH), .COUNT_W(CW), .PERIOD_W(PW), .BASIC_PERIOD(BP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tif(tif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_outputs(int e);
    for (int c = 0; c < CH; c++) begin
      m_busy[c] = (m_st[c] == 1);
      m_done[c] = (m_st[c] == 2);
      m_rem[c]  = (m_st[c] == 1) ? (m_dl[c] - e + BP - 1) / BP : 0;
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_st[c] = 0;
      q_exp[c].delete();
    end
    model_outputs(cyc);
  endtask

  // predict the effect of the upcoming edge given the inputs now applied
  task automatic model_step();
    int e;
    e = cyc + 1;
    for (int c = 0; c < CH; c++) begin
      if (!tif.enable) begin
        m_st[c] = 0;
      end else if (tif.start[c]) begin
        m_d[c]  = int'(tif.delay[c*CW +: CW]);
        m_md[c] = tif.mode[c];
        if (m_d[c] == 0) begin
          m_st[c] = 2;
          q_exp[c].push_back(e);
        end else begin
          m_st[c] = 1;
          m_dl[c] = e + m_d[c] * BP;
        end
      end else if (m_st[c] == 1) begin
        if (tif.pause[c]) begin
          m_dl[c]++;
        end else if (e == m_dl[c]) begin
          q_exp[c].push_back(e);
          if (m_md[c]) m_dl[c] = e + m_d[c] * BP;
          else         m_st[c] = 2;
        end
      end
    end
    model_outputs(e);
  endtask

  task automatic next_cycle();
    model_step();
    @(negedge clk);
    tif.start = '0;
  endtask

  task automatic idle(int n);
    repeat (n) next_cycle();
  endtask

  task automatic kick(int c, int d, bit md, output int t);
    tif.start[c] = 1'b1;
    tif.mode[c]  = md;
    tif.delay[c*CW +: CW] = CW'(d);
    t = cyc + 1;
    next_cycle();
  endtask

  task automatic clear_logs();
    for (int c = 0; c < CH; c++) plog[c].delete();
  endtask

  function automatic int plog_at(int c, int k);
    return (plog[c].size() > k) ? plog[c][k] : -1;
  endfunction

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        for (int c = 0; c < CH; c++) begin
          chk($sformatf("busy[%0d]", c), int'(tif.busy[c]), int'(m_busy[c]));
          chk($sformatf("done[%0d]", c), int'(tif.done[c]), int'(m_done[c]));
          chk($sformatf("remaining[%0d]", c), int'(tif.remaining[c*CW +: CW]), m_rem[c]);
          if (tif.done_pulse[c]) begin
            plog[c].push_back(cyc);
            if (q_exp[c].size() == 0) chk($sformatf("unexpected pulse[%0d]", c), cyc, -1);
            else chk($sformatf("pulse edge[%0d]", c), cyc, q_exp[c].pop_front());
          end else if (q_exp[c].size() > 0 && q_exp[c][0] <= cyc) begin
            chk($sformatf("missing pulse[%0d]", c), -1, q_exp[c].pop_front());
          end
        end
        chk("any_done", int'(tif.any_done), int'(|m_done));
      end
    end
  end

  initial begin : stim
    int t, t1;
    tif.enable = 1'b1;
    tif.start  = '0;
    tif.pause  = '0;
    tif.mode   = '0;
    tif.delay  = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", int'(tif.busy), 0);
    chk("reset done", int'(tif.done), 0);
    chk("reset pulse", int'(tif.done_pulse), 0);
    chk("reset remaining", int'(tif.remaining), 0);
    chk("reset any_done", int'(tif.any_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();

    // one-shot, delay 3
    clear_logs();
    kick(0, 3, 1'b0, t);
    idle(20);
    chk("oneshot pulses", plog[0].size(), 1);
    chk("oneshot edge", plog_at(0, 0), t + 15);
    chk("oneshot held", int'(tif.done[0]), 1);

    // periodic, delay 2
    clear_logs();
    kick(1, 2, 1'b1, t);
    idle(31);
    chk("periodic 1st", plog_at(1, 0), t + 10);
    chk("periodic 2nd", plog_at(1, 1), t + 20);
    chk("periodic 3rd", plog_at(1, 2), t + 30);
    chk("periodic done", int'(tif.done[1]), 0);
    tif.enable = 1'b0;
    next_cycle();
    tif.enable = 1'b1;

    // periodic with 4 paused cycles in the second period
    clear_logs();
    kick(1, 2, 1'b1, t);
    idle(12);
    tif.pause[1] = 1'b1;
    idle(4);
    tif.pause[1] = 1'b0;
    idle(14);
    chk("pause 1st", plog_at(1, 0), t + 10);
    chk("pause 2nd", plog_at(1, 1), t + 24);
    tif.enable = 1'b0;
    next_cycle();
    tif.enable = 1'b1;

    // zero delay
    clear_logs();
    kick(0, 0, 1'b1, t);
    idle(2);
    chk("zero pulse", plog_at(0, 0), t);
    chk("zero busy", int'(tif.busy[0]), 0);
    chk("zero done", int'(tif.done[0]), 1);

    // restart at cycle 7 of a delay-3 run
    clear_logs();
    kick(0, 3, 1'b0, t);
    idle(6);
    kick(0, 4, 1'b0, t1);
    idle(22);
    chk("restart offset", t1 - t, 7);
    chk("restart pulses", plog[0].size(), 1);
    chk("restart edge", plog_at(0, 0), t1 + 20);

    // concurrent channels
    clear_logs();
    tif.start = 2'b11;
    tif.mode  = 2'b00;
    tif.delay = {8'd5, 8'd2};
    t = cyc + 1;
    next_cycle();
    idle(30);
    chk("indep ch0", plog_at(0, 0), t + 10);
    chk("indep ch1", plog_at(1, 0), t + 25);

    // enable abort and start ignored while disabled
    tif.start = 2'b11;
    tif.delay = {8'd3, 8'd4};
    next_cycle();
    idle(7);
    tif.enable = 1'b0;
    next_cycle();
    chk("abort busy", int'(tif.busy), 0);
    chk("abort remaining", int'(tif.remaining), 0);
    tif.start = 2'b11;
    next_cycle();
    chk("disabled start", int'(tif.busy), 0);
    tif.enable = 1'b1;

    // asynchronous reset between edges
    kick(0, 3, 1'b0, t);
    idle(4);
    chk("pre-reset busy", int'(tif.busy[0]), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async busy", int'(tif.busy), 0);
    chk("async done", int'(tif.done), 0);
    chk("async remaining", int'(tif.remaining), 0);
    chk("async any_done", int'(tif.any_done), 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_outputs(cyc);

    // start coinciding with expiry
    clear_logs();
    kick(0, 2, 1'b0, t);
    idle(9);
    kick(0, 1, 1'b0, t1);
    idle(8);
    chk("collide offset", t1 - t, 10);
    chk("collide pulses", plog[0].size(), 1);
    chk("collide edge", plog_at(0, 0), t1 + 5);

    // delay changed mid-run
    clear_logs();
    kick(0, 2, 1'b0, t);
    tif.delay[CW-1:0] = 8'd9;
    idle(12);
    chk("latched delay", plog_at(0, 0), t + 10);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      tif.enable = ($urandom_range(0, 149) != 0);
      for (int c = 0; c < CH; c++) begin
        tif.start[c] = ($urandom_range(0, 34) == 0);
        tif.pause[c] = ($urandom_range(0, 5) == 0);
        tif.mode[c]  = $urandom_range(0, 1) == 1;
        tif.delay[c*CW +: CW] = CW'($urandom_range(0, 6));
      end
      model_step();
      @(negedge clk);
    end
    tif.start = '0;
    tif.pause = '0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_timer_multi.md
# delay_timer_multi

Parametrised, multi-channel successor to the single-shot delay counter used by the lab timing paths. Each channel counts a programmable number of BASIC_PERIOD clock ticks and then either stops with a held `done`, or reloads and repeats. Channels share clock, reset and a global enable but are otherwise fully independent. The block sits between the control FSMs, which issue `start`, and the display/actuator logic, which consumes `done`/`done_pulse`.

## Interface
- CHANNELS, 2: number of independent timer channels (≥1).
- COUNT_W, 8: width of each channel's delay/count field.
- PERIOD_W, 20: width of each channel's sub-counter.
- BASIC_PERIOD, 500000: clk cycles per delay unit (1 ≤ BASIC_PERIOD ≤ 2^PERIOD_W).

- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  global enable; low aborts all channels.
- start  in  CHANNELS  per-channel start/restart strobe; bit i for channel i.
- pause  in  CHANNELS  per-channel hold; freezes the channel while high.
- mode  in  CHANNELS  per-channel mode, sampled with start: 0 = one-shot, 1 = periodic.
- delay  in  CHANNELS*COUNT_W  per-channel delay; channel i in bits [i*COUNT_W +: COUNT_W], sampled with start.
- busy  out  CHANNELS  channel in RUN.
- done  out  CHANNELS  one-shot expiry, held level.
- done_pulse  out  CHANNELS  one-cycle strobe on every expiry, both modes.
- remaining  out  CHANNELS*COUNT_W  current count register per channel.
- any_done  out  1  OR of `done`.

## Operation
- Per-channel state: IDLE, RUN, DONE. Per-channel registers: count (COUNT_W), sub (PERIOD_W), reload value (COUNT_W), mode bit.
- Reset: all channels IDLE; count=0, sub=0; busy, done, done_pulse, any_done = 0; remaining = 0.
- Priority per edge, highest first: `enable`=0, then `start[i]`, then `pause[i]`, then the tick.
- `enable`=0: every channel goes to IDLE with count=0, sub=0 and all outputs 0. `start` is ignored.
- `start[i]`=1 with `enable`=1, from any state (restart allowed mid-RUN and from DONE):
  - Latch delay_i into count and into the reload value. Latch mode_i. Set sub=0, clear done[i].
  - If delay_i≠0: go to RUN.
  - If delay_i=0: go to DONE and pulse done_pulse[i]. Both modes behave as one-shot.
- RUN with `pause[i]`=1: count and sub hold; busy stays 1.
- RUN, not paused:
  - If sub<BASIC_PERIOD-1: sub+1.
  - Otherwise: sub=0 and count-1.
  - When count=1 and sub=BASIC_PERIOD-1, the channel expires:
    - One-shot: go to DONE, count=0, done=1, done_pulse=1.
    - Periodic: stay in RUN, count=reload value, done_pulse=1, done stays 0.
- DONE: done held at 1 and count=0 until the next start or `enable`=0.
- IDLE: no activity.
- Changes on `delay` or `mode` after the start edge have no effect.
- done_pulse is 0 on every cycle except the expiry/zero-delay edge.
- Arithmetic is unsigned. count never wraps below 0. sub never exceeds BASIC_PERIOD-1.

## Timing
- All outputs are registered, except any_done, which is the combinational OR of the registered done.
- Start sampled at edge t with delay D>0 and no pause:
  - busy=1 after edge t.
  - Expiry at edge t+D*BASIC_PERIOD: done and done_pulse visible after that edge; busy falls at the same edge in one-shot.
- Each paused cycle in RUN extends expiry by exactly one cycle.
- Periodic: subsequent expiries every D*BASIC_PERIOD cycles, with no gap cycle at the reload.
- D=0: done and done_pulse visible after edge t. busy never rises.
- Simultaneous `start[i]` and expiry on the same edge: start wins, no pulse, reload with the new delay.
- Simultaneous `start[i]` and `pause[i]`: start wins, and the channel enters RUN while still paused if pause stays high.
- Asynchronous reset mid-RUN: outputs go to 0 immediately, independent of clk.
- BASIC_PERIOD=1: count decrements every unpaused cycle.

## Test plan
All cases use BASIC_PERIOD=5, CHANNELS=2, COUNT_W=8.
- One-shot: ch0 start, delay=3, mode=0. Required: done[0] and a single done_pulse[0] rise 15 cycles after the start edge; busy[0] high for cycles 1..15; done[0] held until the next start.
- Periodic with pause: ch1 delay=2, mode=1. Required: done_pulse[1] at +10, +20 and +30 cycles; done[1] stays 0. Pausing 4 cycles within the second period moves the second pulse to +24.
- Zero delay and restart: delay=0 start gives done and pulse after 1 edge with busy=0. Restarting ch0 with delay=4 at cycle 7 of a delay=3 run gives done at 20 cycles after the restart, with no earlier pulse.
- Independence and enable: both channels run concurrently with different delays and expire independently. Deasserting `enable` mid-run clears busy, done and remaining within 1 edge; `start` with `enable`=0 is ignored.
- Reset and collisions:
  - Assert reset_n=0 mid-RUN between clock edges: all outputs go to 0 asynchronously.
  - After release, a start on the same edge as an expiry produces no pulse and reloads the new delay.
  - Changing `delay` mid-run does not alter expiry time.
